// File: rtl/div_frec_prog.sv
// Runtime-programmable clock divider: divided square wave, one-cycle enable tick,
// and a load/ack handshake that swaps the divisor only at a period boundary.
module div_frec_prog #(
  parameter int unsigned WIDTH       = 26,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_val,
  output logic             load_ack,
  output logic             load_err,
  output logic             pending,
  output logic             tick,
  output logic             clk_out
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pending_d, tick_d, clk_out_d, load_ack_d, load_err_d;

  logic load_ok_c, load_bad_c, terminal_c, idle_c;

  assign load_ok_c  = div_load && (div_val != '0);
  assign load_bad_c = div_load && (div_val == '0);
  // Only the active divisor sets the terminal count; cnt never passes div_q-1.
  assign terminal_c = en && (cnt_q == (div_q - ONE));
  // Cycles with no counting: a waiting divisor can be swapped in immediately.
  assign idle_c     = sync_clr || !en;

  // Next-state logic for counter, divisor and handshake.
  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pending_d  = pending;
    tick_d     = 1'b0;
    clk_out_d  = clk_out;
    load_ack_d = 1'b0;
    load_err_d = load_bad_c;

    if (idle_c) begin
      if (sync_clr) begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
      end
      if (pending) begin
        div_d      = load_ok_c ? div_val : pend_q;
        pend_d     = load_ok_c ? div_val : pend_q;
        pending_d  = 1'b0;
        load_ack_d = 1'b1;
        cnt_d      = '0;
      end else if (load_ok_c) begin
        pend_d    = div_val;
        pending_d = 1'b1;
      end
    end else if (terminal_c) begin
      cnt_d     = '0;
      tick_d    = 1'b1;
      clk_out_d = ~clk_out;
      // A load arriving on the boundary edge itself bypasses the pending stage.
      if (load_ok_c) begin
        div_d      = div_val;
        pend_d     = div_val;
        pending_d  = 1'b0;
        load_ack_d = 1'b1;
      end else if (pending) begin
        div_d      = pend_q;
        pending_d  = 1'b0;
        load_ack_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + ONE;
      if (load_ok_c) begin
        pend_d    = div_val;
        pending_d = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      div_q    <= DIV_RST;
      pend_q   <= '0;
      pending  <= 1'b0;
      tick     <= 1'b0;
      clk_out  <= 1'b0;
      load_ack <= 1'b0;
      load_err <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      pend_q   <= pend_d;
      pending  <= pending_d;
      tick     <= tick_d;
      clk_out  <= clk_out_d;
      load_ack <= load_ack_d;
      load_err <= load_err_d;
    end
  end

endmodule

// File: tb/tb_div_frec_prog.sv
// Bench for div_frec_prog: hand-derived vector table plus a behavioural model
// whose per-cycle predictions are queued and compared after each clock edge.
module tb_div_frec_prog;

  localparam int unsigned W = 26;

  logic         clk_in = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         sync_clr = 1'b0;
  logic         div_load = 1'b0;
  logic [W-1:0] div_val = '0;
  logic         load_ack, load_err, pending, tick, clk_out;

  div_frec_prog #(.WIDTH(W), .DEFAULT_DIV(4)) dut (
    .clk_in(clk_in), .rst(rst), .en(en), .sync_clr(sync_clr),
    .div_load(div_load), .div_val(div_val), .load_ack(load_ack),
    .load_err(load_err), .pending(pending), .tick(tick), .clk_out(clk_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic         r, e, c, l;
    logic [W-1:0] v;
    logic         tick, clk, ack, err, pend;
  } vec_t;

  typedef struct {
    logic tick, clk, ack, err, pend;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural reference state
  logic [W-1:0] m_cnt, m_div, m_pend;
  logic         m_pending, m_tick, m_clk, m_ack, m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = '0; m_div = W'(4); m_pend = '0;
    m_pending = 0; m_tick = 0; m_clk = 0; m_ack = 0; m_err = 0;
  endtask

  task automatic model_step();
    logic ok;
    if (rst) begin
      model_reset();
      return;
    end
    ok = div_load && (div_val != 0);
    m_err = div_load && (div_val == 0);
    m_ack = 0;
    m_tick = 0;
    if (sync_clr || !en) begin
      if (sync_clr) begin m_cnt = 0; m_clk = 0; end
      if (m_pending) begin
        m_div = ok ? div_val : m_pend;
        m_pending = 0; m_ack = 1; m_cnt = 0;
      end else if (ok) begin
        m_pend = div_val; m_pending = 1;
      end
    end else if (m_cnt == m_div - 1) begin
      m_cnt = 0; m_tick = 1; m_clk = ~m_clk;
      if (ok) begin m_div = div_val; m_pending = 0; m_ack = 1; end
      else if (m_pending) begin m_div = m_pend; m_pending = 0; m_ack = 1; end
    end else begin
      m_cnt = m_cnt + 1;
      if (ok) begin m_pend = div_val; m_pending = 1; end
    end
  endtask

  // One clock: drive at negedge, predict, compare #1 after the rising edge.
  task automatic cycle(input logic r, input logic e, input logic c, input logic l,
                       input logic [W-1:0] v);
    exp_t ex;
    @(negedge clk_in);
    rst = r; en = e; sync_clr = c; div_load = l; div_val = v;
    model_step();
    exp_q.push_back('{m_tick, m_clk, m_ack, m_err, m_pending});
    @(posedge clk_in);
    #1;
    ex = exp_q.pop_front();
    check("sb_tick", 32'(tick), 32'(ex.tick));
    check("sb_clk_out", 32'(clk_out), 32'(ex.clk));
    check("sb_load_ack", 32'(load_ack), 32'(ex.ack));
    check("sb_load_err", 32'(load_err), 32'(ex.err));
    check("sb_pending", 32'(pending), 32'(ex.pend));
  endtask

  function automatic void add(logic r, logic e, logic l, logic [W-1:0] v,
                              logic t, logic ck, logic a, logic er, logic p);
    vec_t x;
    x.r = r; x.e = e; x.c = 1'b0; x.l = l; x.v = v;
    x.tick = t; x.clk = ck; x.ack = a; x.err = er; x.pend = p;
    tbl.push_back(x);
  endfunction

  initial begin
    model_reset();

    // Default divisor 4 after reset
    add(1,0,0,0, 0,0,0,0,0);
    for (int k = 1; k <= 12; k++)
      add(0,1,0,0, (k % 4 == 0), (k >= 4 && k < 8) || k == 12, 0,0,0);
    // Load 2 on edge 5; swap with ack at edge 8
    add(1,0,0,0, 0,0,0,0,0);
    add(0,1,0,0, 0,0,0,0,0);
    add(0,1,0,0, 0,0,0,0,0);
    add(0,1,0,0, 0,0,0,0,0);
    add(0,1,0,0, 1,1,0,0,0);
    add(0,1,1,2, 0,1,0,0,1);
    add(0,1,0,0, 0,1,0,0,1);
    add(0,1,0,0, 0,1,0,0,1);
    add(0,1,0,0, 1,0,1,0,0);
    add(0,1,0,0, 0,0,0,0,0);
    add(0,1,0,0, 1,1,0,0,0);
    add(0,1,0,0, 0,1,0,0,0);
    add(0,1,0,0, 1,0,0,0,0);
    // Zero divisor rejected; spacing stays 4
    add(1,0,0,0, 0,0,0,0,0);
    add(0,1,0,0, 0,0,0,0,0);
    add(0,1,1,0, 0,0,0,1,0);
    add(0,1,0,0, 0,0,0,0,0);
    add(0,1,0,0, 1,1,0,0,0);
    add(0,1,0,0, 0,1,0,0,0);
    add(0,1,0,0, 0,1,0,0,0);
    add(0,1,0,0, 0,1,0,0,0);
    add(0,1,0,0, 1,0,0,0,0);

    foreach (tbl[i]) begin
      cycle(tbl[i].r, tbl[i].e, tbl[i].c, tbl[i].l, tbl[i].v);
      check("tbl_tick", 32'(tick), 32'(tbl[i].tick));
      check("tbl_clk_out", 32'(clk_out), 32'(tbl[i].clk));
      check("tbl_load_ack", 32'(load_ack), 32'(tbl[i].ack));
      check("tbl_load_err", 32'(load_err), 32'(tbl[i].err));
      check("tbl_pending", 32'(pending), 32'(tbl[i].pend));
    end

    // Divisor 1 loaded while disabled, then run at clk_in/2
    cycle(1,0,0,0,0);
    cycle(0,0,0,1,1);
    check("d1_pending_set", 32'(pending), 1);
    cycle(0,0,0,0,0);
    check("d1_ack", 32'(load_ack), 1);
    check("d1_pending_clr", 32'(pending), 0);
    for (int k = 1; k <= 6; k++) begin
      cycle(0,1,0,0,0);
      check("d1_tick", 32'(tick), 1);
      check("d1_clk_out", 32'(clk_out), 32'(k % 2));
    end

    // Hold at cnt=2 for five cycles, then tick two enabled cycles later
    cycle(1,0,0,0,0);
    cycle(0,1,0,0,0);
    cycle(0,1,0,0,0);
    for (int k = 0; k < 5; k++) begin
      cycle(0,0,0,0,0);
      check("hold_tick", 32'(tick), 0);
    end
    cycle(0,1,0,0,0);
    check("hold_no_early_tick", 32'(tick), 0);
    cycle(0,1,0,0,0);
    check("hold_resume_tick", 32'(tick), 1);
    check("hold_resume_clk", 32'(clk_out), 1);

    // sync_clr on a terminal edge suppresses tick and toggle
    cycle(0,1,0,0,0);
    cycle(0,1,0,0,0);
    cycle(0,1,0,0,0);
    cycle(0,1,1,0,0);
    check("clr_no_tick", 32'(tick), 0);
    check("clr_clk_low", 32'(clk_out), 0);
    for (int k = 1; k <= 4; k++) cycle(0,1,0,0,0);
    check("clr_restart_tick", 32'(tick), 1);

    // Async reset between edges with a load waiting and clk_out high
    cycle(1,0,0,0,0);
    for (int k = 0; k < 4; k++) cycle(0,1,0,0,0);
    cycle(0,1,0,1,3);
    check("ar_pre_pending", 32'(pending), 1);
    check("ar_pre_clk", 32'(clk_out), 1);
    #2 rst = 1'b1;
    #1;
    check("ar_clk_out", 32'(clk_out), 0);
    check("ar_pending", 32'(pending), 0);
    check("ar_tick", 32'(tick), 0);
    model_reset();
    for (int k = 1; k <= 8; k++) begin
      cycle(0,1,0,0,0);
      check("ar_no_ack", 32'(load_ack), 0);
      check("ar_tick_div4", 32'(tick), 32'(k % 4 == 0));
    end

    // Random traffic against the model
    for (int k = 0; k < 400; k++)
      cycle(0, ($urandom_range(0,9) != 0), ($urandom_range(0,19) == 0),
            ($urandom_range(0,7) == 0), W'($urandom_range(0,5)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
